// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_id_e;

  // Attributes of the request currently being serviced
  typedef struct packed {
    req_id_e id;
    logic    we;
  } req_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection between fetch and data requesters.
// ARB_RR_EN selects round-robin on contention; otherwise data wins.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic    if_valid,
  input  logic    d_valid,
  input  req_id_e last_grant,
  output logic    grant_if,
  output logic    grant_d
);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_valid && d_valid) begin
`ifdef ARB_RR_EN
      if (last_grant == REQ_D) grant_if = 1'b1;
      else                     grant_d  = 1'b1;
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_if = if_valid;
      grant_d  = d_valid;
    end
  end

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM between instruction fetch and load/store, one access in flight.
// Define ARB_RR_EN for round-robin arbitration on contention (default: data over fetch).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range");
  end

  state_e           state;
  req_t             req;
  logic [CNT_W-1:0] cnt;
  req_id_e          last_grant;
  logic             grant_if;
  logic             grant_d;
  logic             accept;
  logic             sel_d;

  mem_arb_picker u_picker (
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant),
    .grant_if   (grant_if),
    .grant_d    (grant_d)
  );

  // Request inputs only matter in IDLE; the picker never grants an invalid requester
  assign if_req_ready = (state == IDLE) && grant_if;
  assign d_req_ready  = (state == IDLE) && grant_d;
  assign accept       = if_req_ready || d_req_ready;
  assign sel_d        = d_req_ready;
  assign busy         = (state != IDLE);

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant <= REQ_IF;
    else if (accept) last_grant <= sel_d ? REQ_D : REQ_IF;
  end
`else
  assign last_grant = REQ_IF;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req          <= '0;
      cnt          <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ISSUE;
            req.id   <= sel_d ? REQ_D : REQ_IF;
            req.we   <= sel_d && d_we;
            mem_en   <= 1'b1;
            mem_we   <= sel_d && d_we;
            mem_addr <= sel_d ? d_addr : if_addr;
            if (sel_d) mem_wdata <= d_wdata;
          end
        end
        ISSUE: begin
          if (req.we) begin
            // A store completes as soon as the write strobe has been presented
            state       <= IDLE;
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= '0;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (req.id == REQ_D) begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LAT = 1;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, MEM_LAT = 1
  logic          if_req_valid = 0, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rsp_data;
  logic          d_req_valid = 0, d_req_ready, d_we = 0, d_rsp_valid;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rsp_data;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Second instance, MEM_LAT = 3
  logic          if3_req_valid = 0, if3_req_ready, if3_rsp_valid;
  logic [AW-1:0] if3_addr = '0;
  logic [DW-1:0] if3_rsp_data;
  logic          d3_req_valid = 0, d3_req_ready, d3_we = 0, d3_rsp_valid;
  logic [AW-1:0] d3_addr = '0;
  logic [DW-1:0] d3_wdata = '0, d3_rsp_data;
  logic          mem3_en, mem3_we, busy3;
  logic [AW-1:0] mem3_addr;
  logic [DW-1:0] mem3_wdata, mem3_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if3_req_valid), .if_req_ready(if3_req_ready), .if_addr(if3_addr),
    .if_rsp_valid(if3_rsp_valid), .if_rsp_data(if3_rsp_data),
    .d_req_valid(d3_req_valid), .d_req_ready(d3_req_ready), .d_we(d3_we), .d_addr(d3_addr),
    .d_wdata(d3_wdata), .d_rsp_valid(d3_rsp_valid), .d_rsp_data(d3_rsp_data),
    .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
    .mem_rdata(mem3_rdata), .busy(busy3)
  );

  function automatic logic [31:0] init_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {8'hC0, b, ~b, 8'h3C};
  endfunction

  // RAM devices: read data is valid only in the cycle MEM_LAT after the strobe, junk otherwise
  logic [31:0] ram1 [256];
  logic [31:0] ram3 [256];
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram1[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram1[mem_addr[7:0]];
    else                   mem_rdata <= $urandom;
  end

  always @(posedge clk) begin
    if (mem3_en && mem3_we) ram3[mem3_addr[7:0]] <= mem3_wdata;
    pipe3[0] <= (mem3_en && !mem3_we) ? ram3[mem3_addr[7:0]] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem3_rdata = pipe3[2];

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference for the main instance
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          free_cyc = 0;
  int          en_cyc = -1;
  bit          en_we;
  logic [15:0] en_addr;
  logic [31:0] en_wdata;
  int          rsp_cyc = -1;
  bit          rsp_d;
  logic [31:0] rsp_data;
  bit          last_was_d = 1'b0;
  bit          obs_grants [$];
  logic [31:0] last_if_data = '0;
  logic [31:0] last_d_data = '0;

  task automatic model_reset();
    free_cyc   = cyc;
    en_cyc     = -1;
    rsp_cyc    = -1;
    last_was_d = 1'b0;
  endtask

  task automatic tick(output bit g_if, output bit g_d);
    bit idle, prefer_if;
    #1;
    idle      = (cyc >= free_cyc);
    prefer_if = RR && last_was_d;
    g_if = idle && if_req_valid && !(d_req_valid && !prefer_if);
    g_d  = idle && d_req_valid && !(if_req_valid && prefer_if);
    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("d_req_ready", 32'(d_req_ready), 32'(g_d));
    if (if_req_valid && if_req_ready) obs_grants.push_back(1'b0);
    else if (d_req_valid && d_req_ready) obs_grants.push_back(1'b1);
    @(posedge clk);
    cyc++;
    if (g_if || g_d) begin
      last_was_d = g_d;
      en_cyc   = cyc;
      en_we    = g_d && d_we;
      en_addr  = g_d ? d_addr : if_addr;
      en_wdata = d_wdata;
      if (en_we) begin
        ref_mem[d_addr[7:0]] = d_wdata;
        rsp_cyc  = cyc + 1;
        rsp_d    = 1'b1;
        rsp_data = '0;
      end else begin
        rsp_cyc  = cyc + LAT + 1;
        rsp_d    = g_d;
        rsp_data = ref_mem[en_addr[7:0]];
      end
      free_cyc = rsp_cyc;
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(cyc < free_cyc));
    check("mem_en", 32'(mem_en), 32'(cyc == en_cyc));
    if (cyc == en_cyc) begin
      check("mem_we", 32'(mem_we), 32'(en_we));
      check("mem_addr", 32'(mem_addr), 32'(en_addr));
      if (en_we) check("mem_wdata", mem_wdata, en_wdata);
    end
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(cyc == rsp_cyc && !rsp_d));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(cyc == rsp_cyc && rsp_d));
    if (cyc == rsp_cyc && !rsp_d) check("if_rsp_data", if_rsp_data, rsp_data);
    if (cyc == rsp_cyc && rsp_d) check("d_rsp_data", d_rsp_data, rsp_data);
    if (if_rsp_valid) last_if_data = if_rsp_data;
    if (d_rsp_valid) last_d_data = d_rsp_data;
  endtask

  task automatic idle_ticks(input int n);
    bit gi, gd;
    for (int i = 0; i < n; i++) tick(gi, gd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One access on the MEM_LAT=3 instance; rst_at >= 0 pulses reset starting after that cycle
  task automatic dut3_txn(input bit is_d, input logic [15:0] addr, input int rst_at,
                          input logic [31:0] exp_data);
    bit exp_busy, exp_rsp;
    d3_req_valid = is_d;
    d3_we        = 1'b0;
    d3_addr      = addr;
    if3_req_valid = !is_d;
    if3_addr      = addr;
    #1;
    check("l3_ready", 32'({if3_req_ready, d3_req_ready}), is_d ? 32'd1 : 32'd2);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d3_req_valid  = 1'b0;
      if3_req_valid = 1'b0;
      exp_busy = (i <= 3) && (rst_at < 0 || i <= rst_at);
      exp_rsp  = (rst_at < 0) && (i == 4);
      check("l3_busy", 32'(busy3), 32'(exp_busy));
      check("l3_mem_en", 32'(mem3_en), 32'(i == 0));
      check("l3_d_rsp_valid", 32'(d3_rsp_valid), 32'(exp_rsp && is_d));
      check("l3_if_rsp_valid", 32'(if3_rsp_valid), 32'(exp_rsp && !is_d));
      if (i == 0) begin
        check("l3_mem_we", 32'(mem3_we), 32'd0);
        check("l3_mem_addr", 32'(mem3_addr), 32'(addr));
        check("l3_mem_wdata", mem3_wdata, 32'd0);
      end
      if (exp_rsp) check("l3_rsp_data", is_d ? d3_rsp_data : if3_rsp_data, exp_data);
      if (i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  initial begin
    bit gi, gd;
    bit exp4 [4];
    bit hold_if, hold_d;
    int n;
    for (int i = 0; i < 256; i++) begin
      ram1[i]    = init_word(i);
      ram3[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ram1[16]    = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;

    // 1: reset, then idle outputs
    do_reset();
    check("rst_ctrl", 32'({if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, mem_en, mem_we, busy}), 32'd0);
    check("rst_data", if_rsp_data | d_rsp_data | mem_wdata | 32'(mem_addr), 32'd0);
    check("rst3_ctrl", 32'({if3_rsp_valid, d3_rsp_valid, mem3_en, mem3_we, busy3}), 32'd0);
    idle_ticks(2);

    // 2: fetch from 0x0010
    if_addr = 16'h0010;
    if_req_valid = 1'b1;
    tick(gi, gd);
    if_req_valid = 1'b0;
    idle_ticks(3);
    check("t2_fetch_data", last_if_data, 32'hDEADBEEF);

    // 3: store then load back
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678;
    tick(gi, gd);
    d_req_valid = 1'b0;
    idle_ticks(1);
    check("t3_store_ack", last_d_data, 32'd0);
    d_req_valid = 1'b1; d_we = 1'b0; d_wdata = '0;
    tick(gi, gd);
    d_req_valid = 1'b0;
    idle_ticks(3);
    check("t3_load_data", last_d_data, 32'h12345678);

    // 4: sustained contention from reset
    do_reset();
    obs_grants.delete();
    if_addr = 16'h0040; if_req_valid = 1'b1;
    d_addr = 16'h0030; d_we = 1'b0; d_req_valid = 1'b1;
    n = 0;
    while (obs_grants.size() < 4 && n < 40) begin
      tick(gi, gd);
      n++;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    idle_ticks(4);
`ifdef ARB_RR_EN
    exp4 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp4 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    check("t4_grant_count", 32'(obs_grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_grants.size()) check("t4_grant", 32'(obs_grants[i]), 32'(exp4[i]));

    // 5: MEM_LAT=3 load
    dut3_txn(1'b1, 16'h0005, -1, init_word(5));

    // 6: reset during WAIT, then a normal fetch
    dut3_txn(1'b1, 16'h0006, 1, init_word(6));
    model_reset();
    dut3_txn(1'b0, 16'h0007, -1, init_word(7));

    // Randomized traffic on the main instance
    hold_if = 1'b0;
    hold_d  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!hold_d) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_we        = 1'($urandom_range(0, 1));
        d_addr      = 16'($urandom_range(0, 31));
        d_wdata     = $urandom;
      end
      if (!hold_if) if_req_valid = 1'($urandom_range(0, 1));
      if (!hold_if || $urandom_range(0, 3) == 0) if_addr = 16'($urandom_range(0, 31));
      tick(gi, gd);
      hold_if = if_req_valid && !gi;
      hold_d  = d_req_valid && !gd;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    idle_ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
